// File: rtl/sim_ctrl_device_if.sv
// Processor data-bus channel between the CPU side (master) and the
// simulation-control device (slave): one request, one timed response strobe.
interface sim_ctrl_device_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sim_ctrl_device.sv
// Simulation-control responder: TOHOST pass/fail flags, console byte FIFO,
// free-running cycle counter with forced timeout, fixed-latency bus responses.
module sim_ctrl_device #(
    parameter logic [31:0] ADDR_BASE      = 32'h8000_0000,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000
) (
    input  logic                    clk,
    input  logic                    rst,
    sim_ctrl_device_if.slave        bus,
    output logic                    con_valid,
    output logic [7:0]              con_data,
    input  logic                    con_ready,
    output logic                    done,
    output logic                    pass,
    output logic [30:0]             fail_code,
    output logic                    timeout
);
    // state | meaning
    // IDLE  | ready for a request; latches write/addr/wdata on req_valid
    // WAIT  | latency countdown, requests held off
    // RESP  | one-cycle response strobe; register side effects commit here
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [2:0]  LAT_INIT = 3'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       tohost_q, tohost_d;
    logic [31:0]       cyc_q, cyc_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [30:0]       fail_q, fail_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0] offset;
    logic        addr_ok;
    logic        resp_now;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        con_wr;
    logic        push;
    logic        tohost_wr;
    logic        tohost_fin;

    always_comb begin
        offset     = addr_q - ADDR_BASE;
        addr_ok    = (offset < 32'd16) && (addr_q[1:0] == 2'b00);
        resp_now   = (state_q == S_RESP);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && con_ready;
        con_wr     = resp_now && wr_q && addr_ok && (offset[3:2] == 2'd1);
        // a full FIFO still accepts when the head leaves in the same cycle
        push       = con_wr && (!fifo_full || pop);
        tohost_wr  = resp_now && wr_q && addr_ok && (offset[3:2] == 2'd0) && !done_q;
        tohost_fin = tohost_wr && wdata_q[0];
    end

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bus.req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    lat_d   = LAT_INIT;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == 3'd1) state_d = S_RESP;
                else               lat_d   = lat_q - 3'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.resp_valid = resp_now;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        if (resp_now) begin
            if (!addr_ok) begin
                bus.resp_err = 1'b1;
            end else if (wr_q) begin
                bus.resp_err = con_wr && !push;
            end else begin
                case (offset[3:2])
                    2'd0:    bus.resp_rdata = tohost_q;
                    2'd1:    bus.resp_rdata = 32'(count_q);
                    2'd2:    bus.resp_rdata = cyc_q;
                    default: bus.resp_rdata = {28'b0, timeout_q, fifo_full, done_q, pass_q};
                endcase
            end
        end
    end

    always_comb begin
        tohost_d  = tohost_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        cyc_d     = done_q ? cyc_q : cyc_q + 32'd1;
        if (tohost_wr) begin
            tohost_d = wdata_q;
            if (wdata_q[0]) begin
                done_d = 1'b1;
                if (wdata_q == 32'd1) pass_d = 1'b1;
                else                  fail_d = wdata_q[31:1];
            end
        end
        // a finishing TOHOST write in the same cycle takes priority over timeout
        if (!done_q && (cyc_q == TIMEOUT_CYCLES - 32'd1) && !tohost_fin) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata_q[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tohost_q  <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            timeout_q <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tohost_q  <= tohost_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign con_valid = !fifo_empty;
    assign con_data  = mem_q[rd_ptr_q];
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_q;
    assign timeout   = timeout_q;
endmodule
